// File: rtl/cpu_pkg.sv
// Shared types and widths for the mini 16-bit CPU pipeline.
// fetch_entry_t travels from the fetch buffer into decode.
package cpu_pkg;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode valid/ready channel carrying the head instruction and its PC.
// Fetch uses the master modport and decode uses the slave modport.
interface fetch_unit_if
  import cpu_pkg::*;
();

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer of fetch entries with push, pop and flush.
// The head entry is read combinationally. Flush wins over push and pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CNT_W-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: storage is reset as well, because the head is visible on the outputs and must read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem address, and a fetch buffer that feeds decode.
// Define FETCH_WRAP_HALT_EN to halt after fetching the last address instead of wrapping.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  fetch_unit_if.master       fetch_out,
  output logic               halted
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q;
  logic              pop, can_push, push;
  fetch_entry_t      head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;

  // A full buffer can still accept a fetch when decode drains the head in the same cycle.
  always_comb begin
    pop      = fetch_out.out_valid && fetch_out.out_ready;
    can_push = !halted_q && (!fifo_full || pop);
    push     = can_push && !redirect_valid;
    pc_d     = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (push) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef FETCH_WRAP_HALT_EN
  logic halted_d;

  always_comb begin
    halted_d = halted_q;
    if (redirect_valid) begin
      halted_d = 1'b0;
    end else if (push && (pc_q == '1)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
`else
  assign halted_q = 1'b0;
`endif

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry ('{pc: pc_q, instr: imem_instr}),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign imem_addr           = pc_q;
  assign halted              = halted_q;
  assign fetch_out.out_valid = !fifo_empty;
  assign fetch_out.out_instr = head.instr;
  assign fetch_out.out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a per-cycle vector table plus hand-written sequences.
// A queue scoreboard checks every accepted instruction.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid = 1'b0;
  logic [ADDR_W-1:0]  redirect_pc = '0;
  logic               halted;

  fetch_unit_if fout ();

  logic [INSTR_W-1:0] mem [16];
  assign imem_instr = mem[imem_addr];

  fetch_unit #(.DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_out      (fout),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  fetch_entry_t sb[$];

  typedef struct {
    logic              ready;
    logic              exp_valid;
    logic [ADDR_W-1:0] exp_pc;
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;
  vec_t bp [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_expect(input logic [ADDR_W-1:0] p);
    sb.push_back('{pc: p, instr: mem[p]});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    fout.out_ready = 1'b0;
    tick();
    tick();
    sb.delete();
    rst = 1'b0;
  endtask

  // Every handshake accepted by decode must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && fout.out_valid && fout.out_ready) begin
      fetch_entry_t e;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got pc %0d, expected no output", fout.out_pc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", 32'(fout.out_pc), 32'(e.pc));
        check("sb_instr", 32'(fout.out_instr), 32'(e.instr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'hA000 | 16'(i);
    mem[0] = 16'h1205;
    mem[1] = 16'h1402;
    mem[2] = 16'h2680;
    fout.out_ready = 1'b0;

    //        ready valid pc addr
    bp[0] = '{1'b0, 1'b0, 4'd0, 4'd0};
    bp[1] = '{1'b0, 1'b1, 4'd0, 4'd1};
    bp[2] = '{1'b0, 1'b1, 4'd0, 4'd2};
    bp[3] = '{1'b0, 1'b1, 4'd0, 4'd2};
    bp[4] = '{1'b0, 1'b1, 4'd0, 4'd2};
    bp[5] = '{1'b1, 1'b1, 4'd0, 4'd2};
    bp[6] = '{1'b1, 1'b1, 4'd1, 4'd3};
    bp[7] = '{1'b1, 1'b1, 4'd2, 4'd4};
    bp[8] = '{1'b0, 1'b1, 4'd3, 4'd5};
    bp[9] = '{1'b0, 1'b1, 4'd3, 4'd5};

    // Reset release with decode always ready
    apply_reset();
    check("rst_valid", 32'(fout.out_valid), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_out_pc", 32'(fout.out_pc), 0);
    check("rst_out_instr", 32'(fout.out_instr), 0);
    check("rst_halted", 32'(halted), 0);
    fout.out_ready = 1'b1;
    sb_expect(0); sb_expect(1); sb_expect(2);
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("stream_c%0d_valid", c), 32'(fout.out_valid), 1);
      check($sformatf("stream_c%0d_pc", c), 32'(fout.out_pc), 32'(c - 1));
    end
    tick();
    fout.out_ready = 1'b0;
    check("stream_drained", 32'(sb.size()), 0);

    // Backpressure from reset, then release
    apply_reset();
    sb_expect(0); sb_expect(1); sb_expect(2);
    for (int i = 0; i < 10; i++) begin
      fout.out_ready = bp[i].ready;
      check($sformatf("bp%0d_valid", i), 32'(fout.out_valid), 32'(bp[i].exp_valid));
      if (bp[i].exp_valid) check($sformatf("bp%0d_pc", i), 32'(fout.out_pc), 32'(bp[i].exp_pc));
      check($sformatf("bp%0d_addr", i), 32'(imem_addr), 32'(bp[i].exp_addr));
      tick();
    end
    check("bp_drained", 32'(sb.size()), 0);

    // Redirect while the buffer is full
    apply_reset();
    tick(); tick(); tick();
    check("rdf_full_valid", 32'(fout.out_valid), 1);
    check("rdf_full_addr", 32'(imem_addr), 2);
    redirect_valid = 1'b1;
    redirect_pc = 4'd5;
    tick();
    redirect_valid = 1'b0;
    check("rdf_n1_valid", 32'(fout.out_valid), 0);
    check("rdf_n1_addr", 32'(imem_addr), 5);
    fout.out_ready = 1'b1;
    sb_expect(5); sb_expect(6);
    tick();
    check("rdf_n2_valid", 32'(fout.out_valid), 1);
    check("rdf_n2_pc", 32'(fout.out_pc), 5);
    tick();
    check("rdf_n3_pc", 32'(fout.out_pc), 6);
    tick();
    fout.out_ready = 1'b0;
    check("rdf_drained", 32'(sb.size()), 0);

    // Redirect in the same cycle as a pop
    apply_reset();
    fout.out_ready = 1'b1;
    sb_expect(0);
    tick();
    check("rdp_head_pc", 32'(fout.out_pc), 0);
    redirect_valid = 1'b1;
    redirect_pc = 4'd9;
    sb_expect(9);
    tick();
    redirect_valid = 1'b0;
    check("rdp_n1_valid", 32'(fout.out_valid), 0);
    tick();
    check("rdp_n2_valid", 32'(fout.out_valid), 1);
    check("rdp_n2_pc", 32'(fout.out_pc), 9);
    tick();
    fout.out_ready = 1'b0;
    check("rdp_drained", 32'(sb.size()), 0);

    // Asynchronous reset pulse between clock edges
    apply_reset();
    fout.out_ready = 1'b1;
    sb_expect(0); sb_expect(1);
    tick(); tick();
    @(negedge clk);
    #2;
    check("ar_pre_valid", 32'(fout.out_valid), 1);
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(fout.out_valid), 0);
    check("ar_addr", 32'(imem_addr), 0);
    check("ar_out_pc", 32'(fout.out_pc), 0);
    check("ar_halted", 32'(halted), 0);
    sb.delete();
    sb_expect(0); sb_expect(1);
    rst = 1'b0;
    tick();
    check("ar_restart_valid", 32'(fout.out_valid), 1);
    check("ar_restart_pc0", 32'(fout.out_pc), 0);
    tick();
    check("ar_restart_pc1", 32'(fout.out_pc), 1);
    tick();
    fout.out_ready = 1'b0;
    check("ar_drained", 32'(sb.size()), 0);

    // End of memory after a redirect to pc 14
    apply_reset();
    fout.out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 4'd14;
    tick();
    redirect_valid = 1'b0;
    check("eom_addr", 32'(imem_addr), 14);
    sb_expect(14); sb_expect(15);
`ifndef FETCH_WRAP_HALT_EN
    sb_expect(0); sb_expect(1);
`endif
    tick();
    check("eom_pc14", 32'(fout.out_pc), 14);
    tick();
    check("eom_pc15", 32'(fout.out_pc), 15);
`ifdef FETCH_WRAP_HALT_EN
    check("eom_halted", 32'(halted), 1);
    tick();
    check("eom_idle_valid", 32'(fout.out_valid), 0);
    check("eom_idle_halted", 32'(halted), 1);
    tick();
    check("eom_still_idle", 32'(fout.out_valid), 0);
    tick();
    fout.out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 4'd3;
    tick();
    redirect_valid = 1'b0;
    check("eom_unhalt", 32'(halted), 0);
    check("eom_unhalt_addr", 32'(imem_addr), 3);
`else
    check("eom_halted", 32'(halted), 0);
    tick();
    check("eom_wrap_pc0", 32'(fout.out_pc), 0);
    tick();
    check("eom_wrap_pc1", 32'(fout.out_pc), 1);
    check("eom_halted_low", 32'(halted), 0);
    tick();
    fout.out_ready = 1'b0;
`endif
    check("eom_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
